// File: rtl/sha256_multiblock_core_if.sv
// Block-in / digest-out handshake bundle for the SHA-256 multiblock core.
// The master side offers blocks and consumes digests; the slave side is the core.
interface sha256_multiblock_core_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic [511:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_digest;

  modport master (
    output in_valid, in_first, in_last, in_block, out_ready,
    input  in_ready, out_valid, out_digest
  );

  modport slave (
    input  in_valid, in_first, in_last, in_block, out_ready,
    output in_ready, out_valid, out_digest
  );
endinterface

// File: rtl/sha256_multiblock_core.sv
// SHA-256 compression over chained pre-padded 512-bit blocks, UNROLL rounds per
// clock, with message expansion done on the fly in a 16-word sliding window.
module sha256_multiblock_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  sha256_multiblock_core_if.slave  bus,
  output logic                     busy
);

  localparam int unsigned NROUND_CYC = 64 / UNROLL;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_multiblock_core: UNROLL must be 1, 2, 4 or 8");
  end

  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_e;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t bsig0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t bsig1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t ssig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e         state_q, state_d;
  word_t          h_q  [8];
  word_t          h_d  [8];
  word_t          wv_q [8];
  word_t          wv_d [8];
  word_t          w_q  [16];
  word_t          w_d  [16];
  word_t          rnd_v [8];
  word_t          rnd_w [16];
  logic [5:0]     cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           ov_q, ov_d;
  logic [255:0]   dig_q, dig_d;
  logic           in_rdy;

  assign in_rdy         = (state_q == IDLE) && !reset;
  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = ov_q;
  assign bus.out_digest = dig_q;
  assign busy           = (state_q != IDLE);

  // wx[j] is W[t+j]; the window always holds W[t..t+15], so the new words
  // computed here are W[t+16..t+15+UNROLL] and become the next window tail.
  always_comb begin : round_comb
    word_t wx [16+UNROLL];
    word_t v  [8];
    word_t t1, t2;
    for (int unsigned i = 0; i < 16; i++) wx[i] = w_q[i];
    for (int unsigned j = 0; j < UNROLL; j++)
      wx[16+j] = ssig1(wx[14+j]) + wx[9+j] + ssig0(wx[1+j]) + wx[j];
    v = wv_q;
    for (int unsigned j = 0; j < UNROLL; j++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + K[cnt_q + 6'(j)] + wx[j];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
    rnd_v = v;
    for (int unsigned i = 0; i < 16; i++) rnd_w[i] = wx[i+UNROLL];
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    wv_d    = wv_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ov_d    = ov_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_rdy) begin
          for (int unsigned i = 0; i < 16; i++) w_d[i] = bus.in_block[511-32*i -: 32];
          last_d = bus.in_last;
          if (bus.in_first) begin
            h_d  = IV;
            wv_d = IV;
          end else begin
            wv_d = h_q;
          end
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        wv_d  = rnd_v;
        w_d   = rnd_w;
        cnt_d = cnt_q + 6'(UNROLL);
        if (cnt_q == 6'(UNROLL * (NROUND_CYC - 1))) state_d = FINAL;
      end
      FINAL: begin
        for (int unsigned i = 0; i < 8; i++) begin
          h_d[i]                 = h_q[i] + wv_q[i];
          dig_d[255-32*i -: 32]  = h_q[i] + wv_q[i];
        end
        if (last_q) begin
          ov_d    = 1'b1;
          state_d = OUT;
        end else begin
          dig_d   = dig_q;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      h_q     <= IV;
      wv_q    <= '{default: '0};
      w_q     <= '{default: '0};
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ov_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      wv_q    <= wv_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ov_q    <= ov_d;
      dig_q   <= dig_d;
    end
  end

endmodule
